// File: rtl/retire_trace_buffer_pkg.sv
// Shared types for the retire trace buffer: record layout, serializer states, beat indices.
// Combinational helper only; no state, no flow control.
package retire_trace_buffer_pkg;

   localparam int RECORD_W = 128;
   localparam int BEAT_W   = 32;

   localparam logic [1:0] BEAT_PC = 2'd0;
   localparam logic [1:0] BEAT_WD = 2'd1;
   localparam logic [1:0] BEAT_HI = 2'd2;
   localparam logic [1:0] BEAT_LO = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_B0,
      ST_B1,
      ST_B2,
      ST_B3
   } state_t;

   typedef struct packed {
      logic [BEAT_W-1:0] pc;
      logic [BEAT_W-1:0] wdata;
      logic [BEAT_W-1:0] hi;
      logic [BEAT_W-1:0] lo;
   } record_t;

   function automatic logic [BEAT_W-1:0] beat_field(input record_t rec, input logic [1:0] idx);
      logic [BEAT_W-1:0] field;
      case (idx)
         BEAT_PC: field = rec.pc;
         BEAT_WD: field = rec.wdata;
         BEAT_HI: field = rec.hi;
         default: field = rec.lo;
      endcase
      return field;
   endfunction

endpackage

// File: rtl/retire_trace_buffer_trace_fifo.sv
// Circular DEPTH x W record FIFO; head visible combinationally, one-cycle write latency.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module trace_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 128
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [W-1:0]           push_data,
   input  logic                   pop,
   output logic [W-1:0]           pop_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

   // DEPTH is a power of two, so pointer wrap DEPTH-1 -> 0 is the natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/retire_trace_buffer.sv
// Captures one 128-bit record per PC change into a FIFO and drains it as four 32-bit beats.
// First beat valid one edge after capture; the core is never stalled, overflow drops and counts.
module retire_trace_buffer
   import retire_trace_buffer_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DROP_W = 16
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic                   Enable,
   input  logic [31:0]            PCValue,
   input  logic [31:0]            WriteData,
   input  logic [31:0]            HiData,
   input  logic [31:0]            LoData,
   output logic [31:0]            OutData,
   output logic                   OutValid,
   input  logic                   OutReady,
   output logic                   OutLast,
   output logic [$clog2(DEPTH):0] Count,
   output logic                   Full,
   output logic                   Empty,
   output logic [DROP_W-1:0]      DropCount,
   input  logic                   ClearDrops
);

   logic [31:0] last_pc;
   logic        first;
   logic        capture;
   logic        push;
   logic        pop;
   logic        drop;
   record_t     new_rec;
   record_t     head;
   record_t     hold;
   state_t      state;
   state_t      state_nxt;

   assign capture = Enable && (first || (PCValue != last_pc));
   assign pop     = !Empty && ((state == ST_IDLE) || ((state == ST_B3) && OutReady));
   assign push    = capture && (!Full || pop);
   assign drop    = capture && !push;
   assign new_rec = '{pc: PCValue, wdata: WriteData, hi: HiData, lo: LoData};

   trace_fifo #(
      .DEPTH (DEPTH),
      .W     (RECORD_W)
   ) u_fifo (
      .clk       (Clk),
      .rst_n     (Rst),
      .push      (push),
      .push_data (new_rec),
      .pop       (pop),
      .pop_data  (head),
      .count     (Count),
      .full      (Full),
      .empty     (Empty)
   );

   // LastPC tracks every qualifying PC, even ones whose record is dropped.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         last_pc <= '0;
         first   <= 1'b1;
      end else if (capture) begin
         last_pc <= PCValue;
         first   <= 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         DropCount <= '0;
      end else if (ClearDrops) begin
         DropCount <= '0;
      end else if (drop && !(&DropCount)) begin
         DropCount <= DropCount + DROP_W'(1);
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         hold <= '0;
      end else if (pop) begin
         hold <= head;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (!Empty)  state_nxt = ST_B0;
         ST_B0:   if (OutReady) state_nxt = ST_B1;
         ST_B1:   if (OutReady) state_nxt = ST_B2;
         ST_B2:   if (OutReady) state_nxt = ST_B3;
         ST_B3:   if (OutReady) state_nxt = Empty ? ST_IDLE : ST_B0;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      OutValid = 1'b0;
      OutLast  = 1'b0;
      OutData  = '0;
      case (state)
         ST_B0: begin
            OutValid = 1'b1;
            OutData  = beat_field(hold, BEAT_PC);
         end
         ST_B1: begin
            OutValid = 1'b1;
            OutData  = beat_field(hold, BEAT_WD);
         end
         ST_B2: begin
            OutValid = 1'b1;
            OutData  = beat_field(hold, BEAT_HI);
         end
         ST_B3: begin
            OutValid = 1'b1;
            OutLast  = 1'b1;
            OutData  = beat_field(hold, BEAT_LO);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer: ordering, stalls, overflow, async reset, drop saturation.
module tb_retire_trace_buffer;

   logic        Clk;
   logic        Rst;
   logic        Enable;
   logic [31:0] PCValue;
   logic [31:0] WriteData;
   logic [31:0] HiData;
   logic [31:0] LoData;
   logic [31:0] OutData;
   logic        OutValid;
   logic        OutReady;
   logic        OutLast;
   logic [4:0]  Count;
   logic        Full;
   logic        Empty;
   logic [15:0] DropCount;
   logic        ClearDrops;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   retire_trace_buffer #(.DEPTH(16), .DROP_W(16)) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .Enable     (Enable),
      .PCValue    (PCValue),
      .WriteData  (WriteData),
      .HiData     (HiData),
      .LoData     (LoData),
      .OutData    (OutData),
      .OutValid   (OutValid),
      .OutReady   (OutReady),
      .OutLast    (OutLast),
      .Count      (Count),
      .Full       (Full),
      .Empty      (Empty),
      .DropCount  (DropCount),
      .ClearDrops (ClearDrops)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for a valid beat, checks it, then lets the handshake edge pass.
   task automatic get_beat(input string tag, input logic [31:0] exp_data, input logic exp_last);
      int n;
      n = 0;
      while (!OutValid && n < 16) begin
         tick();
         n++;
      end
      if (!OutValid) begin
         checks++;
         fails++;
         $error("FAIL %s: observed no OutValid within 16 cycles expected a beat", tag);
      end else begin
         check(tag, OutData, exp_data);
         check({tag, "_last"}, {31'b0, OutLast}, {31'b0, exp_last});
         tick();
      end
   endtask

   task automatic set_rec(input logic [31:0] pc, input logic [31:0] wd,
                          input logic [31:0] hi, input logic [31:0] lo);
      PCValue   = pc;
      WriteData = wd;
      HiData    = hi;
      LoData    = lo;
   endtask

   initial begin
      Rst        = 1'b0;
      Enable     = 1'b0;
      OutReady   = 1'b1;
      ClearDrops = 1'b0;
      set_rec(0, 0, 0, 0);
      tick();
      tick();
      check("rst_valid", {31'b0, OutValid}, 0);
      check("rst_last",  {31'b0, OutLast}, 0);
      check("rst_data",  OutData, 0);
      check("rst_count", {27'b0, Count}, 0);
      check("rst_empty", {31'b0, Empty}, 1);
      check("rst_full",  {31'b0, Full}, 0);
      check("rst_drop",  {16'b0, DropCount}, 0);
      @(negedge Clk);
      Rst = 1'b1;
      tick();

      // 1: three records back to back
      Enable = 1'b1;
      set_rec(32'h0, 32'hA, 32'h1, 32'h2);
      tick();
      check("t1_valid_after_capture", {31'b0, OutValid}, 0);
      check("t1_count1", {27'b0, Count}, 1);
      set_rec(32'h4, 32'hB, 32'h1, 32'h2);
      tick();
      check("t1_first_valid", {31'b0, OutValid}, 1);
      check("t1_b0", OutData, 32'h0);
      check("t1_b0_last", {31'b0, OutLast}, 0);
      set_rec(32'h8, 32'hC, 32'h1, 32'h2);
      tick();
      Enable = 1'b0;
      get_beat("t1_b1", 32'hA, 0);
      get_beat("t1_b2", 32'h1, 0);
      get_beat("t1_b3", 32'h2, 1);
      get_beat("t1_b4", 32'h4, 0);
      get_beat("t1_b5", 32'hB, 0);
      get_beat("t1_b6", 32'h1, 0);
      get_beat("t1_b7", 32'h2, 1);
      get_beat("t1_b8", 32'h8, 0);
      get_beat("t1_b9", 32'hC, 0);
      get_beat("t1_b10", 32'h1, 0);
      get_beat("t1_b11", 32'h2, 1);
      check("t1_idle", {31'b0, OutValid}, 0);
      check("t1_empty", {31'b0, Empty}, 1);

      // 2: stalled PC yields a single record
      OutReady = 1'b0;
      Enable   = 1'b1;
      set_rec(32'h10, 32'h100, 32'h1, 32'h2);
      for (int i = 0; i < 5; i++) tick();
      set_rec(32'h14, 32'h104, 32'h1, 32'h2);
      tick();
      Enable = 1'b0;
      tick();
      check("t2_count", {27'b0, Count}, 1);
      check("t2_drop", {16'b0, DropCount}, 0);
      check("t2_hold_pc", OutData, 32'h10);
      OutReady = 1'b1;
      get_beat("t2_r0_pc", 32'h10, 0);
      get_beat("t2_r0_wd", 32'h100, 0);
      get_beat("t2_r0_hi", 32'h1, 0);
      get_beat("t2_r0_lo", 32'h2, 1);
      get_beat("t2_r1_pc", 32'h14, 0);
      get_beat("t2_r1_wd", 32'h104, 0);
      get_beat("t2_r1_hi", 32'h1, 0);
      get_beat("t2_r1_lo", 32'h2, 1);
      tick();
      tick();
      check("t2_no_third", {31'b0, OutValid}, 0);

      // 3: overflow with consumer blocked
      OutReady = 1'b0;
      Enable   = 1'b1;
      for (int i = 0; i < 20; i++) begin
         set_rec(32'h100 + 4*i, 32'h1000 + i, 32'h200 + i, 32'h300 + i);
         tick();
      end
      Enable = 1'b0;
      check("t3_count", {27'b0, Count}, 16);
      check("t3_full", {31'b0, Full}, 1);
      check("t3_drop", {16'b0, DropCount}, 3);
      check("t3_hold_pc", OutData, 32'h100);
      OutReady = 1'b1;
      for (int i = 0; i < 17; i++) begin
         get_beat("t3_pc", 32'h100 + 4*i, 0);
         get_beat("t3_wd", 32'h1000 + i, 0);
         get_beat("t3_hi", 32'h200 + i, 0);
         get_beat("t3_lo", 32'h300 + i, 1);
      end
      check("t3_empty", {31'b0, Empty}, 1);
      check("t3_idle", {31'b0, OutValid}, 0);
      ClearDrops = 1'b1;
      tick();
      ClearDrops = 1'b0;
      check("t3_cleared", {16'b0, DropCount}, 0);

      // 4: stall mid-record keeps beat stable
      OutReady = 1'b0;
      Enable   = 1'b1;
      set_rec(32'h500, 32'h55, 32'h66, 32'h77);
      tick();
      Enable = 1'b0;
      tick();
      check("t4_b0", OutData, 32'h500);
      OutReady = 1'b1;
      tick();
      OutReady = 1'b0;
      check("t4_b1", OutData, 32'h55);
      tick();
      check("t4_b1_hold1", OutData, 32'h55);
      check("t4_b1_hold1_last", {31'b0, OutLast}, 0);
      tick();
      check("t4_b1_hold2", OutData, 32'h55);
      OutReady = 1'b1;
      tick();
      check("t4_b2", OutData, 32'h66);
      tick();
      OutReady = 1'b0;
      check("t4_b3", OutData, 32'h77);
      tick();
      check("t4_b3_hold", OutData, 32'h77);
      check("t4_b3_hold_last", {31'b0, OutLast}, 1);
      check("t4_b3_hold_valid", {31'b0, OutValid}, 1);
      OutReady = 1'b1;
      tick();
      check("t4_done", {31'b0, OutValid}, 0);

      // 5: asynchronous reset in B2 with three records queued
      OutReady = 1'b0;
      Enable   = 1'b1;
      for (int k = 0; k < 4; k++) begin
         set_rec(32'h600 + 4*k, 32'h700 + k, 32'h800 + k, 32'h900 + k);
         tick();
      end
      Enable = 1'b0;
      check("t5_count3", {27'b0, Count}, 3);
      OutReady = 1'b1;
      tick();
      tick();
      OutReady = 1'b0;
      check("t5_b2", OutData, 32'h800);
      #2;
      Rst = 1'b0;
      #1;
      check("t5_rst_valid", {31'b0, OutValid}, 0);
      check("t5_rst_count", {27'b0, Count}, 0);
      check("t5_rst_empty", {31'b0, Empty}, 1);
      check("t5_rst_data", OutData, 0);
      @(negedge Clk);
      Rst = 1'b1;
      tick();
      OutReady = 1'b1;
      Enable   = 1'b1;
      set_rec(32'h60C, 32'hAB, 32'hCD, 32'hEF);
      tick();
      Enable = 1'b0;
      check("t5_recapture", {27'b0, Count}, 1);
      get_beat("t5_pc", 32'h60C, 0);
      get_beat("t5_wd", 32'hAB, 0);
      get_beat("t5_hi", 32'hCD, 0);
      get_beat("t5_lo", 32'hEF, 1);
      check("t5_idle", {31'b0, OutValid}, 0);

      // 6: drop counter saturation and clear priority
      OutReady = 1'b0;
      Enable   = 1'b1;
      for (int i = 0; i < 17 + 65535; i++) begin
         PCValue = 32'h10000 + 4*i;
         tick();
      end
      check("t6_full", {31'b0, Full}, 1);
      check("t6_sat", {16'b0, DropCount}, 32'hFFFF);
      PCValue = 32'h4;
      tick();
      check("t6_sat_hold", {16'b0, DropCount}, 32'hFFFF);
      ClearDrops = 1'b1;
      PCValue    = 32'h8;
      tick();
      ClearDrops = 1'b0;
      check("t6_clear_wins", {16'b0, DropCount}, 0);
      PCValue = 32'hC;
      tick();
      Enable = 1'b0;
      check("t6_recount", {16'b0, DropCount}, 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
